// File: rtl/mux_2to1_pkg.sv
// Shared constants and helpers for the mux_2to1 selector family.
// Optional select statistics are enabled with MUX_2TO1_SEL_STATS_EN.
package mux_2to1_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned STATS_W       = 16;

  typedef logic [STATS_W-1:0] stats_cnt_t;

  localparam stats_cnt_t STATS_MAX = '1;

  // Saturating increment: sticks at STATS_MAX instead of wrapping to zero.
  function automatic stats_cnt_t sat_inc(input stats_cnt_t cnt);
    return (cnt == STATS_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mux_2to1_core.sv
// Pure combinational WIDTH-bit 2:1 select, y = s ? b : a.
module mux_2to1_core #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = s ? b : a;
  end

endmodule

// File: rtl/mux_2to1.sv
// 2:1 data selector with combinational and registered outputs.
// Define MUX_2TO1_SEL_STATS_EN to add saturating per-input select counters.
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid
`ifdef MUX_2TO1_SEL_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      sel_b_cnt,
  output logic [15:0]      sel_a_cnt
`endif
);

  logic [WIDTH-1:0] y_sel;

  mux_2to1_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a(a),
    .b(b),
    .s(s),
    .y(y_sel)
  );

  assign y = y_sel;

  // y_q holds its value on idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= RESET_VAL;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q <= y_sel;
      end
    end
  end

`ifdef MUX_2TO1_SEL_STATS_EN
  stats_cnt_t cnt_b;
  stats_cnt_t cnt_a;

  // Clear has priority over a coincident count event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_b <= '0;
      cnt_a <= '0;
    end else if (stats_clr) begin
      cnt_b <= '0;
      cnt_a <= '0;
    end else if (in_valid) begin
      if (s) begin
        cnt_b <= sat_inc(cnt_b);
      end else begin
        cnt_a <= sat_inc(cnt_a);
      end
    end
  end

  assign sel_b_cnt = cnt_b;
  assign sel_a_cnt = cnt_a;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed scoreboard bench for mux_2to1 (WIDTH=8 and WIDTH=1 instances).
// Stats checks are compiled in when MUX_2TO1_SEL_STATS_EN is defined.
module tb_mux_2to1;

  typedef struct {
    logic [7:0] yq;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b, y, y_q;
  logic       s, in_valid, out_valid;
  logic       a1, b1, s1, y1, yq1, ov1;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  exp_t       sb_q[$];
  logic [7:0] model_yq;

`ifdef MUX_2TO1_SEL_STATS_EN
  logic        stats_clr;
  logic [15:0] sel_b_cnt, sel_a_cnt, sbc1, sac1;
  logic [15:0] m_cnt_b, m_cnt_a;
`endif

  always #5 clk = ~clk;

  mux_2to1 #(
    .WIDTH(8),
    .RESET_VAL(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .s(s),
    .in_valid(in_valid),
    .y(y),
    .y_q(y_q),
    .out_valid(out_valid)
`ifdef MUX_2TO1_SEL_STATS_EN
    ,
    .stats_clr(stats_clr),
    .sel_b_cnt(sel_b_cnt),
    .sel_a_cnt(sel_a_cnt)
`endif
  );

  mux_2to1 #(
    .WIDTH(1)
  ) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .a(a1),
    .b(b1),
    .s(s1),
    .in_valid(1'b0),
    .y(y1),
    .y_q(yq1),
    .out_valid(ov1)
`ifdef MUX_2TO1_SEL_STATS_EN
    ,
    .stats_clr(1'b0),
    .sel_b_cnt(sbc1),
    .sel_a_cnt(sac1)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check y combinationally, then check y_q/out_valid after the edge.
  task automatic cycle(input logic [7:0] na, input logic [7:0] nb, input logic ns, input logic nv);
    exp_t e;
    exp_t got;
    a        = na;
    b        = nb;
    s        = ns;
    in_valid = nv;
    #1;
    check("y_comb", {8'h00, y}, {8'h00, (ns ? nb : na)});
    e.yq = nv ? (ns ? nb : na) : model_yq;
    e.ov = nv;
    sb_q.push_back(e);
`ifdef MUX_2TO1_SEL_STATS_EN
    if (stats_clr) begin
      m_cnt_b = '0;
      m_cnt_a = '0;
    end else if (nv) begin
      if (ns) m_cnt_b = (m_cnt_b == 16'hFFFF) ? m_cnt_b : m_cnt_b + 16'd1;
      else    m_cnt_a = (m_cnt_a == 16'hFFFF) ? m_cnt_a : m_cnt_a + 16'd1;
    end
`endif
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    model_yq = got.yq;
    check("y_q", {8'h00, y_q}, {8'h00, got.yq});
    check("out_valid", {15'd0, out_valid}, {15'd0, got.ov});
  endtask

  initial begin
    logic [7:0] tt_exp;
    logic [2:0] k;
    tt_exp   = 8'b1010_1100;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    s        = 1'b0;
    in_valid = 1'b0;
    a1       = 1'b0;
    b1       = 1'b0;
    s1       = 1'b0;
    model_yq = 8'h00;
`ifdef MUX_2TO1_SEL_STATS_EN
    stats_clr = 1'b0;
    m_cnt_b   = '0;
    m_cnt_a   = '0;
`endif

    // Truth table on the 1-bit instance, held in reset (y must still work)
    for (int i = 0; i < 8; i++) begin
      k  = 3'(i);
      s1 = k[2];
      a1 = k[1];
      b1 = k[0];
      #10;
      check($sformatf("truth_%0d", i), {15'd0, y1}, {15'd0, tt_exp[i]});
    end

    check("rst_y_q", {8'h00, y_q}, 16'h0000);
    check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_y_q_w1", {15'd0, yq1}, 16'h0000);
    check("rst_out_valid_w1", {15'd0, ov1}, 16'h0000);
`ifdef MUX_2TO1_SEL_STATS_EN
    check("rst_sel_b_cnt", sel_b_cnt, 16'h0000);
    check("rst_sel_a_cnt", sel_a_cnt, 16'h0000);
    check("rst_sel_b_cnt_w1", sbc1, 16'h0000);
    check("rst_sel_a_cnt_w1", sac1, 16'h0000);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Registered capture then an idle cycle
    cycle(8'h3C, 8'hA5, 1'b1, 1'b1);
    cycle(8'h3C, 8'hA5, 1'b1, 1'b0);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y_q", {8'h00, y_q}, 16'h0000);
    check("async_rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_y_tracks_b", {8'h00, y}, 16'h00A5);
    s = 1'b0;
    #1;
    check("rst_y_tracks_a", {8'h00, y}, 16'h003C);
    model_yq = 8'h00;
`ifdef MUX_2TO1_SEL_STATS_EN
    check("async_rst_sel_b_cnt", sel_b_cnt, 16'h0000);
    m_cnt_b = '0;
    m_cnt_a = '0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle first cycle after reset keeps RESET_VAL, then select toggles each cycle
    cycle(8'h11, 8'h22, 1'b0, 1'b0);
    cycle(8'h11, 8'h22, 1'b0, 1'b1);
    cycle(8'h11, 8'h22, 1'b1, 1'b1);
    cycle(8'h11, 8'h22, 1'b0, 1'b1);
    cycle(8'h11, 8'h22, 1'b1, 1'b1);

    // All-ones / all-zeros data boundaries
    cycle(8'hFF, 8'h00, 1'b0, 1'b1);
    cycle(8'hFF, 8'h00, 1'b1, 1'b1);

`ifdef MUX_2TO1_SEL_STATS_EN
    check("stats_pre_clr_b", sel_b_cnt, m_cnt_b);
    check("stats_pre_clr_a", sel_a_cnt, m_cnt_a);
    // Clear coinciding with a count event: clear wins
    stats_clr = 1'b1;
    cycle(8'h01, 8'h02, 1'b1, 1'b1);
    stats_clr = 1'b0;
    check("stats_clr_b", sel_b_cnt, 16'h0000);
    check("stats_clr_a", sel_a_cnt, 16'h0000);

    for (int i = 0; i < 5; i++) cycle(8'h01, 8'h02, 1'b1, 1'b1);
    check("stats_five_b", sel_b_cnt, 16'd5);
    check("stats_five_a", sel_a_cnt, 16'd0);

    // Drive sel_a_cnt past its maximum
    a        = 8'h01;
    b        = 8'h02;
    s        = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    model_yq = 8'h01;
    m_cnt_a  = 16'hFFFF;
    check("stats_sat_a", sel_a_cnt, 16'hFFFF);
    check("stats_sat_b_hold", sel_b_cnt, 16'd5);
    cycle(8'h01, 8'h02, 1'b0, 1'b1);
    check("stats_sat_a_hold", sel_a_cnt, 16'hFFFF);
    stats_clr = 1'b1;
    cycle(8'h01, 8'h02, 1'b0, 1'b0);
    stats_clr = 1'b0;
    check("stats_clr2_a", sel_a_cnt, 16'h0000);
    check("stats_clr2_b", sel_b_cnt, 16'h0000);
`endif

    check("scoreboard_empty", 16'(sb_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
